rc4_key_search_ctrl: RTL and testbench

//  Brute-force key-search sequencer for the RC4 datapath (init/shuffle/decrypt/checker chain).

---
 rtl/rc4_pkg.sv | 23 ++
 rtl/rc4_key_search_ctrl_watchdog.sv | 42 ++++
 rtl/rc4_key_search_ctrl.sv | 176 +++++++++++++++++
 tb/tb_rc4_key_search_ctrl.sv | 321 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rc4_pkg.sv
// Shared types and defaults for the RC4 brute-force key-search controller.
package rc4_pkg;

   localparam int RC4_KEY_W       = 24;
   localparam int RC4_TIMEOUT_CYC = 4096;

   // Sequencer states, from idle through one decrypt per key to a terminal verdict.
   typedef enum logic [2:0] {
      IDLE,
      LAUNCH,
      WAIT,
      EVAL,
      FOUND,
      EXHAUSTED,
      ERROR
   } ks_state_t;

   // Counter width able to hold values 0..cycles-1, never narrower than one bit.
   function automatic int wdWidth(input int cycles);
      return (cycles > 1) ? $clog2(cycles) : 1;
   endfunction

endpackage

// File: rtl/rc4_key_search_ctrl_watchdog.sv
// Per-key watchdog: counts cycles while enabled and flags the last permitted cycle.
module cycle_watchdog
   import rc4_pkg::*;
#(
   parameter int TIMEOUT_CYC = RC4_TIMEOUT_CYC
) (
   input  logic clk,
   input  logic reset_n,
   input  logic clear,
   input  logic enable,
   output logic expired
);

   localparam int CNT_W = wdWidth(TIMEOUT_CYC);
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(TIMEOUT_CYC - 1);

   logic [CNT_W-1:0] count_q;
   logic [CNT_W-1:0] count_d;

   // Expiry is the cycle on which the count reaches its final value.
   assign expired = (count_q == LAST_CNT);

   // Clear wins over counting; the count saturates once it has expired.
   always_comb begin
      count_d = count_q;
      if (clear) begin
         count_d = '0;
      end else if (enable && !expired) begin
         count_d = count_q + 1'b1;
      end
   end

   // Count register.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

endmodule

// File: rtl/rc4_key_search_ctrl.sv
// Brute-force key-search sequencer: walks candidate keys through the RC4 core,
// one full decrypt per key, stopping on the first valid key or at the end of range.
module rc4_key_search_ctrl
   import rc4_pkg::*;
#(
   parameter int               KEY_W       = RC4_KEY_W,
   parameter logic [KEY_W-1:0] KEY_START   = '0,
   parameter logic [KEY_W-1:0] KEY_END     = '1,
   parameter int               TIMEOUT_CYC = RC4_TIMEOUT_CYC
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             go,
   input  logic             resume,
   input  logic             abort,
   output logic             core_start,
   output logic [KEY_W-1:0] core_key,
   input  logic             core_done,
   input  logic             core_valid,
   output logic             core_ack,
   output logic             busy,
   output logic             found,
   output logic             exhausted,
   output logic             timeout_err,
   output logic [KEY_W-1:0] found_key,
   output logic [KEY_W:0]   keys_tried
);

   ks_state_t        state_q, state_d;
   logic [KEY_W-1:0] core_key_q, core_key_d;
   logic [KEY_W-1:0] found_key_q, found_key_d;
   logic [KEY_W:0]   keys_tried_q, keys_tried_d;
   logic             verdict_q, verdict_d;
   logic             core_start_q, core_start_d;
   logic             core_ack_q, core_ack_d;
   logic             busy_q, busy_d;
   logic             found_q, found_d;
   logic             exhausted_q, exhausted_d;
   logic             timeout_q, timeout_d;
   logic             wd_clear;
   logic             wd_enable;
   logic             wd_expired;

   cycle_watchdog #(
      .TIMEOUT_CYC(TIMEOUT_CYC)
   ) u_watchdog (
      .clk    (clk),
      .reset_n(reset_n),
      .clear  (wd_clear),
      .enable (wd_enable),
      .expired(wd_expired)
   );

   // Next-state and datapath decisions; abort overrides everything, then go, then resume.
   // The key advance after a failed verdict happens in the first LAUNCH cycle (while the
   // ack is on the wire) so core_key stays stable until the core sees core_ack.
   always_comb begin
      state_d      = state_q;
      core_key_d   = core_key_q;
      found_key_d  = found_key_q;
      keys_tried_d = keys_tried_q;
      verdict_d    = verdict_q;
      core_start_d = 1'b0;
      core_ack_d   = 1'b0;
      wd_clear     = 1'b0;
      wd_enable    = 1'b0;

      if (abort) begin
         state_d = IDLE;
      end else begin
         unique case (state_q)
            IDLE, EXHAUSTED, ERROR: begin
               if (go) begin
                  state_d      = LAUNCH;
                  core_key_d   = KEY_START;
                  keys_tried_d = '0;
                  found_key_d  = '0;
               end
            end
            LAUNCH: begin
               if (core_ack_q) begin
                  core_key_d = core_key_q + 1'b1;
               end else if (!core_done) begin
                  core_start_d = 1'b1;
                  wd_clear     = 1'b1;
                  state_d      = WAIT;
               end
            end
            WAIT: begin
               wd_enable = 1'b1;
               if (core_done) begin
                  verdict_d = core_valid;
                  state_d   = EVAL;
               end else if (wd_expired) begin
                  state_d = ERROR;
               end
            end
            EVAL: begin
               core_ack_d   = 1'b1;
               keys_tried_d = keys_tried_q + 1'b1;
               if (verdict_q) begin
                  found_key_d = core_key_q;
                  state_d     = FOUND;
               end else if (core_key_q == KEY_END) begin
                  state_d = EXHAUSTED;
               end else begin
                  state_d = LAUNCH;
               end
            end
            FOUND: begin
               if (go) begin
                  state_d      = LAUNCH;
                  core_key_d   = KEY_START;
                  keys_tried_d = '0;
                  found_key_d  = '0;
               end else if (resume) begin
                  if (found_key_q == KEY_END) begin
                     state_d = EXHAUSTED;
                  end else begin
                     core_key_d = found_key_q + 1'b1;
                     state_d    = LAUNCH;
                  end
               end
            end
            default: begin
               state_d = IDLE;
            end
         endcase
      end

      busy_d      = (state_d == LAUNCH) || (state_d == WAIT) || (state_d == EVAL);
      found_d     = (state_d == FOUND);
      exhausted_d = (state_d == EXHAUSTED);
      timeout_d   = (state_d == ERROR);
   end

   // State, datapath and registered status flags.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q      <= IDLE;
         core_key_q   <= KEY_START;
         found_key_q  <= '0;
         keys_tried_q <= '0;
         verdict_q    <= 1'b0;
         core_start_q <= 1'b0;
         core_ack_q   <= 1'b0;
         busy_q       <= 1'b0;
         found_q      <= 1'b0;
         exhausted_q  <= 1'b0;
         timeout_q    <= 1'b0;
      end else begin
         state_q      <= state_d;
         core_key_q   <= core_key_d;
         found_key_q  <= found_key_d;
         keys_tried_q <= keys_tried_d;
         verdict_q    <= verdict_d;
         core_start_q <= core_start_d;
         core_ack_q   <= core_ack_d;
         busy_q       <= busy_d;
         found_q      <= found_d;
         exhausted_q  <= exhausted_d;
         timeout_q    <= timeout_d;
      end
   end

   assign core_start  = core_start_q;
   assign core_key    = core_key_q;
   assign core_ack    = core_ack_q;
   assign busy        = busy_q;
   assign found       = found_q;
   assign exhausted   = exhausted_q;
   assign timeout_err = timeout_q;
   assign found_key   = found_key_q;
   assign keys_tried  = keys_tried_q;

endmodule

// File: tb/tb_rc4_key_search_ctrl.sv
// Directed bench for rc4_key_search_ctrl with a behavioural stub of the RC4 core.
module tb_rc4_key_search_ctrl;

   localparam int KEY_W       = 24;
   localparam int TIMEOUT_CYC = 32;
   localparam int BUDGET      = 2000;
   localparam int DONE_DELAY  = 10;

   logic             clk;
   logic             reset_n;
   logic             go;
   logic             resume;
   logic             abort;
   logic             core_start;
   logic [KEY_W-1:0] core_key;
   logic             core_done;
   logic             core_valid;
   logic             core_ack;
   logic             busy;
   logic             found;
   logic             exhausted;
   logic             timeout_err;
   logic [KEY_W-1:0] found_key;
   logic [KEY_W:0]   keys_tried;

   int passCount  = 0;
   int totalCount = 0;

   rc4_key_search_ctrl #(
      .KEY_W      (KEY_W),
      .KEY_START  (24'd0),
      .KEY_END    (24'd15),
      .TIMEOUT_CYC(TIMEOUT_CYC)
   ) dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .go         (go),
      .resume     (resume),
      .abort      (abort),
      .core_start (core_start),
      .core_key   (core_key),
      .core_done  (core_done),
      .core_valid (core_valid),
      .core_ack   (core_ack),
      .busy       (busy),
      .found      (found),
      .exhausted  (exhausted),
      .timeout_err(timeout_err),
      .found_key  (found_key),
      .keys_tried (keys_tried)
   );

   // Free-running clock, period 10.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Cycle counter used for latency measurements.
   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // Core stub: raises done DONE_DELAY cycles after start, valid only for keys in
   // validMask, keeps done high for holdAfter cycles once the ack is seen.
   logic [15:0]      validMask = '0;
   logic             neverDone = 1'b0;
   int               holdAfter = 1;
   logic             stubClear = 1'b0;
   logic [KEY_W-1:0] stubKey;
   int               stubCnt;
   int               holdCnt;
   logic             stubRun;
   logic             stubAckSeen;

   always @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         core_done <= 1'b0; core_valid <= 1'b0; stubRun <= 1'b0;
         stubAckSeen <= 1'b0; stubCnt <= 0; holdCnt <= 0; stubKey <= '0;
      end else if (stubClear) begin
         core_done <= 1'b0; core_valid <= 1'b0; stubRun <= 1'b0;
         stubAckSeen <= 1'b0; stubCnt <= 0; holdCnt <= 0;
      end else begin
         if (core_start) begin
            stubRun <= 1'b1;
            stubCnt <= 1;
            stubKey <= core_key;
         end else if (stubRun && !core_done && !neverDone) begin
            if (stubCnt == DONE_DELAY - 1) begin
               core_done  <= 1'b1;
               core_valid <= (stubKey < 16) ? validMask[stubKey[3:0]] : 1'b0;
            end else begin
               stubCnt <= stubCnt + 1;
            end
         end
         if (core_done && core_ack) begin
            stubRun <= 1'b0;
            if (holdAfter <= 1) begin
               core_done <= 1'b0; core_valid <= 1'b0;
            end else begin
               stubAckSeen <= 1'b1; holdCnt <= 1;
            end
         end else if (stubAckSeen) begin
            if (holdCnt >= holdAfter - 1) begin
               core_done <= 1'b0; core_valid <= 1'b0; stubAckSeen <= 1'b0;
            end else begin
               holdCnt <= holdCnt + 1;
            end
         end
      end
   end

   // Pulse monitor: counts starts/acks and records the cycles they happened on.
   int   startCount = 0;
   int   ackCount = 0;
   int   lastStartCycle = 0;
   int   lastAckCycle = 0;
   int   gapAckToStart = 0;
   int   startWhileDone = 0;
   int   toRiseCycle = 0;
   logic prevTo = 1'b0;

   always @(negedge clk) begin
      if (core_start) begin
         startCount++;
         lastStartCycle = cyc;
         gapAckToStart  = cyc - lastAckCycle;
         if (core_done) startWhileDone++;
      end
      if (core_ack) begin
         ackCount++;
         lastAckCycle = cyc;
      end
      if (timeout_err && !prevTo) toRiseCycle = cyc;
      prevTo = timeout_err;
   end

   typedef struct {
      string       name;
      logic        useResume;
      logic [15:0] mask;
      logic        noDone;
      logic        expFound;
      logic        expExh;
      logic        expTo;
      logic        chkFoundKey;
      int          expFoundKey;
      int          expKeysTried;
      int          expCoreKey;
      int          expStarts;
      int          expAcks;
      logic        chkGap;
   } vec_t;

   function automatic vec_t makeVec(string n, logic r, logic [15:0] m, logic nd,
                                    logic f, logic e, logic t, logic cfk, int fk,
                                    int kt, int ck, int st, int ak, logic cg);
      vec_t v;
      v.name = n; v.useResume = r; v.mask = m; v.noDone = nd;
      v.expFound = f; v.expExh = e; v.expTo = t; v.chkFoundKey = cfk;
      v.expFoundKey = fk; v.expKeysTried = kt; v.expCoreKey = ck;
      v.expStarts = st; v.expAcks = ak; v.chkGap = cg;
      return v;
   endfunction

   task automatic checkOutput(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
      totalCount++;
      if (actual === expected) begin
         passCount++;
      end else begin
         $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
      end
   endtask

   task automatic stepCycle();
      @(negedge clk);
      #1;
   endtask

   task automatic applyStimulus(input logic useResume);
      if (useResume) resume = 1'b1;
      else go = 1'b1;
      stepCycle();
      go = 1'b0;
      resume = 1'b0;
   endtask

   task automatic configStub(input logic [15:0] m, input logic nd, input int hold);
      validMask = m;
      neverDone = nd;
      holdAfter = hold;
      stubClear = 1'b1;
      stepCycle();
      stubClear = 1'b0;
   endtask

   task automatic waitTerminal(input string name);
      int waited = 0;
      while (!(found || exhausted || timeout_err) && waited < BUDGET) begin
         stepCycle();
         waited++;
      end
      checkOutput({name, "_terminal"}, 32'(waited < BUDGET), 1);
   endtask

   task automatic waitStartKey(input int key, input string name);
      int waited = 0;
      while (!(core_start && core_key == KEY_W'(key)) && waited < BUDGET) begin
         stepCycle();
         waited++;
      end
      checkOutput({name, "_start_seen"}, 32'(waited < BUDGET), 1);
   endtask

   task automatic checkResetValues(input string name);
      checkOutput({name, "_busy"}, 32'(busy), 0);
      checkOutput({name, "_found"}, 32'(found), 0);
      checkOutput({name, "_exhausted"}, 32'(exhausted), 0);
      checkOutput({name, "_timeout"}, 32'(timeout_err), 0);
      checkOutput({name, "_core_start"}, 32'(core_start), 0);
      checkOutput({name, "_core_ack"}, 32'(core_ack), 0);
      checkOutput({name, "_core_key"}, 32'(core_key), 0);
      checkOutput({name, "_found_key"}, 32'(found_key), 0);
      checkOutput({name, "_keys_tried"}, 32'(keys_tried), 0);
   endtask

   vec_t vecs[6];

   initial begin
      int s0;
      int a0;

      vecs[0] = makeVec("find5",     1'b0, 16'h0020, 1'b0, 1, 0, 0, 1, 5,  6,  5,  6,  6,  0);
      vecs[1] = makeVec("resume12",  1'b1, 16'h1020, 1'b0, 1, 0, 0, 1, 12, 13, 12, 7,  7,  0);
      vecs[2] = makeVec("resumeEnd", 1'b1, 16'h1020, 1'b0, 0, 1, 0, 1, 12, 16, 15, 3,  3,  0);
      vecs[3] = makeVec("noneValid", 1'b0, 16'h0000, 1'b0, 0, 1, 0, 0, 0,  16, 15, 16, 16, 0);
      vecs[4] = makeVec("timeout",   1'b0, 16'h0000, 1'b1, 0, 0, 1, 0, 0,  0,  0,  1,  0,  1);
      vecs[5] = makeVec("restart",   1'b0, 16'h0008, 1'b0, 1, 0, 0, 1, 3,  4,  3,  4,  4,  0);

      reset_n = 1'b0;
      go = 1'b0;
      resume = 1'b0;
      abort = 1'b0;
      repeat (2) stepCycle();
      checkResetValues("reset");
      reset_n = 1'b1;
      stepCycle();

      for (int i = 0; i < 6; i++) begin
         configStub(vecs[i].mask, vecs[i].noDone, 1);
         s0 = startCount;
         a0 = ackCount;
         applyStimulus(vecs[i].useResume);
         waitTerminal(vecs[i].name);
         repeat (5) stepCycle();
         checkOutput({vecs[i].name, "_found"}, 32'(found), 32'(vecs[i].expFound));
         checkOutput({vecs[i].name, "_exhausted"}, 32'(exhausted), 32'(vecs[i].expExh));
         checkOutput({vecs[i].name, "_timeout"}, 32'(timeout_err), 32'(vecs[i].expTo));
         checkOutput({vecs[i].name, "_busy"}, 32'(busy), 0);
         checkOutput({vecs[i].name, "_keys_tried"}, 32'(keys_tried), 32'(vecs[i].expKeysTried));
         checkOutput({vecs[i].name, "_core_key"}, 32'(core_key), 32'(vecs[i].expCoreKey));
         checkOutput({vecs[i].name, "_starts"}, 32'(startCount - s0), 32'(vecs[i].expStarts));
         checkOutput({vecs[i].name, "_acks"}, 32'(ackCount - a0), 32'(vecs[i].expAcks));
         if (vecs[i].chkFoundKey)
            checkOutput({vecs[i].name, "_found_key"}, 32'(found_key), 32'(vecs[i].expFoundKey));
         if (vecs[i].chkGap)
            checkOutput({vecs[i].name, "_start_to_err"}, 32'(toRiseCycle - lastStartCycle), 32);
      end
      checkOutput("ack_to_start_default", 32'(gapAckToStart), 2);

      // Go while busy is ignored; abort on the cycle done rises suppresses the ack.
      configStub(16'h0000, 1'b0, 1);
      applyStimulus(1'b0);
      waitStartKey(1, "busyGo");
      s0 = startCount;
      go = 1'b1;
      stepCycle();
      go = 1'b0;
      repeat (3) stepCycle();
      checkOutput("busyGo_core_key", 32'(core_key), 1);
      checkOutput("busyGo_starts", 32'(startCount - s0), 0);
      checkOutput("busyGo_busy", 32'(busy), 1);
      waitStartKey(3, "abort");
      repeat (DONE_DELAY) stepCycle();
      a0 = ackCount;
      abort = 1'b1;
      stepCycle();
      abort = 1'b0;
      checkOutput("abort_busy", 32'(busy), 0);
      repeat (3) stepCycle();
      checkOutput("abort_acks", 32'(ackCount - a0), 0);
      checkOutput("abort_core_key", 32'(core_key), 3);
      checkOutput("abort_keys_tried", 32'(keys_tried), 3);
      checkOutput("abort_found", 32'(found), 0);

      // Done held high after the ack delays the next launch until it falls.
      configStub(16'h0004, 1'b0, 6);
      applyStimulus(1'b0);
      waitTerminal("holdDone");
      repeat (3) stepCycle();
      checkOutput("holdDone_found_key", 32'(found_key), 2);
      checkOutput("holdDone_keys_tried", 32'(keys_tried), 3);
      checkOutput("holdDone_ack_to_start", 32'(gapAckToStart), 7);
      checkOutput("start_while_done", 32'(startWhileDone), 0);

      // Asynchronous reset in the middle of a WAIT.
      configStub(16'h0000, 1'b0, 1);
      applyStimulus(1'b0);
      waitStartKey(1, "midReset");
      repeat (3) stepCycle();
      checkOutput("midReset_busy_before", 32'(busy), 1);
      reset_n = 1'b0;
      #1;
      checkResetValues("midReset");
      stepCycle();
      reset_n = 1'b1;
      stepCycle();

      $display("%0d/%0d checks passed", passCount, totalCount);
      $finish;
   end

endmodule
